// File: rtl/dmem_pkg.sv
// Shared decode definitions for the data-side memory responder:
// I/O register offsets, STATUS bit positions and the address-decode enum.
package dmem_pkg;

  localparam logic [31:0] TXDATA_OFS = 32'h0;
  localparam logic [31:0] STATUS_OFS = 32'h4;
  localparam logic [31:0] CYCLES_OFS = 32'h8;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;

  typedef enum logic [2:0] {
    RAM,
    TXDATA,
    STATUS,
    CYCLES,
    NONE
  } dec_e;

endpackage

// File: rtl/data_mem_responder_tx_fifo.sv
// Byte output FIFO with a combinational head; a push while full is accepted
// only when a pop frees a slot on the same edge.
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the top masks the head while empty.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder: word RAM plus TXDATA/STATUS/CYCLES I/O registers.
// The CYCLES counter is built only when DMEM_CYCLE_COUNTER_EN is defined.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int          RAM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] IO_BASE    = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int          AW       = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_SIZE = 32'(RAM_WORDS * 4);
  localparam logic [31:0] TX_ADDR  = IO_BASE + TXDATA_OFS;
  localparam logic [31:0] ST_ADDR  = IO_BASE + STATUS_OFS;
  localparam logic [31:0] CY_ADDR  = IO_BASE + CYCLES_OFS;

  logic [31:0] ram_q [RAM_WORDS];
  logic [AW-1:0] ram_idx;
  dec_e        dec;
  logic        wr_en;
  logic        ovf_q, ovf_d;
  logic        fifo_empty, fifo_full, fifo_pop, push_req;
  logic [7:0]  fifo_dout;
  logic [31:0] cycles_q;
  logic [31:0] status_word;
  logic        unused_ok;

  assign unused_ok = ^addr[1:0];
  assign ram_idx   = addr[AW+1:2];
  assign wr_en     = we && !rst;

  always_comb begin
    dec = NONE;
    if (addr < RAM_SIZE)                 dec = RAM;
    else if (addr[31:2] == TX_ADDR[31:2]) dec = TXDATA;
    else if (addr[31:2] == ST_ADDR[31:2]) dec = STATUS;
    else if (addr[31:2] == CY_ADDR[31:2]) dec = CYCLES;
  end

  always_ff @(posedge clk) begin
    if (wr_en && dec == RAM) ram_q[ram_idx] <= wdata;
  end

  assign push_req = we && (dec == TXDATA);
  assign fifo_pop = out_valid && out_ready;

  tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .din   (wdata[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? 8'h00 : fifo_dout;

  // Overflow set is applied after the clear so a same-cycle set wins.
  always_comb begin
    ovf_d = ovf_q;
    if (we && dec == STATUS) ovf_d = 1'b0;
    if (push_req && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycles_d;

  always_comb begin
    cycles_d = cycles_q + 32'd1;
    if (we && dec == CYCLES) cycles_d = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) cycles_q <= '0;
    else     cycles_q <= cycles_d;
  end
`else
  assign cycles_q = '0;
`endif

  always_comb begin
    status_word             = '0;
    status_word[STAT_EMPTY] = fifo_empty;
    status_word[STAT_FULL]  = fifo_full;
    status_word[STAT_OVF]   = ovf_q;
  end

  always_comb begin
    rdata = '0;
    case (dec)
      RAM:     rdata = ram_q[ram_idx];
      STATUS:  rdata = status_word;
      CYCLES:  rdata = cycles_q;
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder; CYCLES expectations
// follow DMEM_CYCLE_COUNTER_EN.
module tb_data_mem_responder;

  localparam logic [31:0] TXA = 32'h0000_1000;
  localparam logic [31:0] STA = 32'h0000_1004;
  localparam logic [31:0] CYA = 32'h0000_1008;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic [31:0] rdata;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .rdata     (rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a; we = 1'b0;
    #1;
    check(tag, rdata, exp);
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    rd("reset_status", STA, 32'h1);
    check("reset_valid", {31'b0, out_valid}, 32'h0);
    check("reset_data", {24'b0, out_data}, 32'h0);

    // RAM round trip and aliasing of addr[1:0]
    wr(32'h10, 32'hDEAD_BEEF);
    rd("ram_10", 32'h10, 32'hDEAD_BEEF);
    rd("ram_13", 32'h13, 32'hDEAD_BEEF);
    wr(32'h14, 32'h1234_5678);
    rd("ram_14", 32'h14, 32'h1234_5678);
    rd("ram_10_kept", 32'h10, 32'hDEAD_BEEF);
    addr = 32'h14; wdata = 32'hCAFE_F00D; we = 1'b1;
    #1;
    check("ram_rw_old", rdata, 32'h1234_5678);
    tick();
    we = 1'b0;
    rd("ram_rw_new", 32'h14, 32'hCAFE_F00D);
    rd("unmapped", 32'h2000, 32'h0);
    rd("txdata_rd", TXA, 32'h0);
    wr(32'h2000, 32'h1);
    rd("status_after_unmapped_wr", STA, 32'h1);

    // Two pushes, then drain
    wr(TXA, 32'h141);
    check("push_valid", {31'b0, out_valid}, 32'h1);
    check("push_head", {24'b0, out_data}, 32'h41);
    wr(TXA, 32'h42);
    rd("status_two", STA, 32'h0);
    check("head_still_41", {24'b0, out_data}, 32'h41);
    out_ready = 1'b1;
    tick();
    check("pop_head_42", {24'b0, out_data}, 32'h42);
    tick();
    out_ready = 1'b0;
    check("drained_valid", {31'b0, out_valid}, 32'h0);
    rd("drained_status", STA, 32'h1);

    // Fill and overflow
    for (int i = 0; i < 8; i++) wr(TXA, i);
    rd("full_status", STA, 32'h2);
    wr(TXA, 32'h08);
    rd("ovf_status", STA, 32'h6);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_%0d", i), {23'b0, out_valid, out_data}, 32'h100 | i);
      tick();
    end
    out_ready = 1'b0;
    rd("empty_ovf_status", STA, 32'h5);
    wr(STA, 32'h0);
    rd("ovf_cleared", STA, 32'h1);

    // Push and pop on the same edge while full
    for (int i = 0; i < 8; i++) wr(TXA, 32'h10 + i);
    out_ready = 1'b1;
    wr(TXA, 32'hAA);
    out_ready = 1'b0;
    rd("full_pushpop_status", STA, 32'h2);
    check("full_pushpop_head", {24'b0, out_data}, 32'h11);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("pp_drain_%0d", i), {24'b0, out_data}, (i == 7) ? 32'hAA : 32'h11 + i);
      tick();
    end
    out_ready = 1'b0;
    rd("pp_final_status", STA, 32'h1);

    // Cycle counter load and wrap
    wr(CYA, 32'hFFFF_FFFE);
`ifdef DMEM_CYCLE_COUNTER_EN
    rd("cyc_0", CYA, 32'hFFFF_FFFE);
    tick();
    rd("cyc_1", CYA, 32'hFFFF_FFFF);
    tick();
    rd("cyc_2", CYA, 32'h0000_0000);
`else
    rd("cyc_0", CYA, 32'h0);
    tick();
    rd("cyc_1", CYA, 32'h0);
    tick();
    rd("cyc_2", CYA, 32'h0);
`endif

    // Reset mid-operation drops queued bytes and the in-flight write
    wr(TXA, 32'h55);
    check("pre_rst_valid", {31'b0, out_valid}, 32'h1);
    rst = 1'b1; addr = 32'h10; wdata = 32'h0; we = 1'b1;
    tick();
    rst = 1'b0; we = 1'b0;
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_data", {24'b0, out_data}, 32'h0);
    rd("rst_ram_kept", 32'h10, 32'hDEAD_BEEF);
    rd("rst_status", STA, 32'h1);
`ifdef DMEM_CYCLE_COUNTER_EN
    rd("rst_cycles", CYA, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
